bus_switch: RTL and testbench

BUS_SWITCH -- requirements
Module: bus_switch

---
 rtl/bus_switch.sv | 166 ++++++++++++++++
 tb/tb_bus_switch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_switch.sv
// Single-master to NSLAVES address-decoded bus switch with a per-request timeout.
// A request is latched, steered to one slave, and answered with a one-cycle ready or error pulse.
module bus_switch #(
  parameter int unsigned               NSLAVES    = 4,
  parameter logic [NSLAVES*32-1:0]     BASE_ADDR  = '0,
  parameter logic [NSLAVES*5-1:0]      ADDR_WIDTH = '0,
  parameter int unsigned               TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               master_address,
  input  logic [31:0]               master_wdata,
  input  logic [3:0]                master_wsel,
  input  logic                      master_valid,
  output logic [31:0]               master_rdata,
  output logic                      master_ready,
  output logic                      master_error,
  output logic [31:0]               slave_address,
  output logic [31:0]               slave_wdata,
  output logic [3:0]                slave_wsel,
  output logic [NSLAVES-1:0]        slave_valid,
  input  logic [NSLAVES*32-1:0]     slave_rdata,
  input  logic [NSLAVES-1:0]        slave_ready,
  input  logic [NSLAVES-1:0]        slave_error
);

  localparam int unsigned IDX_W     = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  ACCESS    = 2'd1;
  localparam logic [1:0]  RESP      = 2'd2;
  localparam logic [15:0] TIMEOUT_C = TIMEOUT[15:0];

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wsel_q, wsel_d;
  logic [NSLAVES-1:0] valid_q, valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;

  logic [4:0]         match_count;
  logic [IDX_W-1:0]   match_idx;
  logic [4:0]         span;

  // Address decode: count matching windows and remember the last matching slave
  always_comb begin
    match_count = 5'd0;
    match_idx   = '0;
    span        = 5'd0;
    for (int i = 0; i < NSLAVES; i++) begin
      span = ADDR_WIDTH[i*5 +: 5];
      if ((master_address >> span) == (BASE_ADDR[i*32 +: 32] >> span)) begin
        match_count = match_count + 5'd1;
        match_idx   = i[IDX_W-1:0];
      end else begin
        match_count = match_count;
      end
    end
  end

  // Next-state and output logic for the IDLE/ACCESS/RESP transaction sequencer
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wsel_d  = wsel_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (master_valid) begin
          if (match_count == 5'd1) begin
            addr_d           = master_address;
            wdata_d          = master_wdata;
            wsel_d           = master_wsel;
            sel_d            = match_idx;
            cnt_d            = 16'd0;
            valid_d          = '0;
            valid_d[match_idx] = 1'b1;
            state_d          = ACCESS;
          end else begin
            error_d = 1'b1;
            rdata_d = 32'd0;
            valid_d = '0;
            state_d = RESP;
          end
        end else begin
          valid_d = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 16'd1;
        // Error beats ready; any response beats the timeout
        if (slave_error[sel_q]) begin
          error_d = 1'b1;
          rdata_d = 32'd0;
          valid_d = '0;
          state_d = RESP;
        end else if (slave_ready[sel_q]) begin
          ready_d = 1'b1;
          rdata_d = slave_rdata[{sel_q, 5'd0} +: 32];
          valid_d = '0;
          state_d = RESP;
        end else if ((TIMEOUT_C != 16'd0) && (cnt_d == TIMEOUT_C)) begin
          error_d = 1'b1;
          rdata_d = 32'd0;
          valid_d = '0;
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        valid_d = '0;
        state_d = IDLE;
      end
      default: begin
        valid_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= 16'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wsel_q  <= 4'd0;
      valid_q <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wsel_q  <= wsel_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign master_rdata  = rdata_q;
  assign master_ready  = ready_q;
  assign master_error  = error_q;
  assign slave_address = addr_q;
  assign slave_wdata   = wdata_q;
  assign slave_wsel    = wsel_q;
  assign slave_valid   = valid_q;

endmodule

// File: tb/tb_bus_switch.sv
// Directed, table-driven bench for bus_switch: four slaves, TIMEOUT=8,
// slave 3 deliberately overlaps slave 1 to create a multi-match window.
module tb_bus_switch;

  localparam int K_READY = 0;
  localparam int K_ERROR = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;

  logic         clk;
  logic         rst;
  logic [31:0]  master_address;
  logic [31:0]  master_wdata;
  logic [3:0]   master_wsel;
  logic         master_valid;
  logic [31:0]  master_rdata;
  logic         master_ready;
  logic         master_error;
  logic [31:0]  slave_address;
  logic [31:0]  slave_wdata;
  logic [3:0]   slave_wsel;
  logic [3:0]   slave_valid;
  logic [127:0] slave_rdata;
  logic [3:0]   slave_ready;
  logic [3:0]   slave_error;

  int passed = 0;
  int total  = 0;

  bus_switch #(
    .NSLAVES    (4),
    .BASE_ADDR  ({32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .ADDR_WIDTH ({5'd8, 5'd16, 5'd16, 5'd16}),
    .TIMEOUT    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .master_address (master_address),
    .master_wdata   (master_wdata),
    .master_wsel    (master_wsel),
    .master_valid   (master_valid),
    .master_rdata   (master_rdata),
    .master_ready   (master_ready),
    .master_error   (master_error),
    .slave_address  (slave_address),
    .slave_wdata    (slave_wdata),
    .slave_wsel     (slave_wsel),
    .slave_valid    (slave_valid),
    .slave_rdata    (slave_rdata),
    .slave_ready    (slave_ready),
    .slave_error    (slave_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    int          delay;      // cycles slave_valid is high before the response is sampled
    int          kind;
    logic [31:0] rsp_rdata;
    logic [3:0]  exp_sv;     // 0 means a decode error is expected
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive_slaves(input logic [3:0] sel, input logic rdy, input logic err,
                              input logic [31:0] data);
    for (int j = 0; j < 4; j++) begin
      slave_rdata[j*32 +: 32] = sel[j] ? data : (32'hBBBB_0000 | 32'(j));
    end
    slave_ready = (~sel) | (rdy ? sel : 4'd0);
    slave_error = (~sel) | (err ? sel : 4'd0);
  endtask

  task automatic clear_slaves();
    slave_rdata = '0;
    slave_ready = 4'd0;
    slave_error = 4'd0;
  endtask

  task automatic do_txn(input vec_t v);
    master_address = v.addr;
    master_wdata   = v.wdata;
    master_wsel    = v.wsel;
    master_valid   = 1'b1;
    tick();
    if (v.exp_sv == 4'd0) begin
      chk("decode_sv", {28'd0, slave_valid}, 32'd0);
      chk("decode_err", {31'd0, master_error}, 32'd1);
      chk("decode_rdy", {31'd0, master_ready}, 32'd0);
      chk("decode_rdata", master_rdata, 32'd0);
    end else begin
      for (int c = 0; c < v.delay; c++) begin
        chk("access_sv", {28'd0, slave_valid}, {28'd0, v.exp_sv});
        chk("access_addr", slave_address, v.addr);
        chk("access_wdata", slave_wdata, v.wdata);
        chk("access_wsel", {28'd0, slave_wsel}, {28'd0, v.wsel});
        chk("access_quiet", {30'd0, master_ready, master_error}, 32'd0);
        if (c == v.delay - 1) begin
          drive_slaves(v.exp_sv, (v.kind == K_READY) || (v.kind == K_BOTH),
                       (v.kind == K_ERROR) || (v.kind == K_BOTH), v.rsp_rdata);
        end else begin
          drive_slaves(v.exp_sv, 1'b0, 1'b0, 32'h5555_AAAA);
        end
        tick();
      end
      chk("resp_sv", {28'd0, slave_valid}, 32'd0);
      chk("resp_rdy", {31'd0, master_ready}, {31'd0, ~v.exp_err});
      chk("resp_err", {31'd0, master_error}, {31'd0, v.exp_err});
      chk("resp_rdata", master_rdata, v.exp_rdata);
    end
    master_valid = 1'b0;
    clear_slaves();
    tick();
    chk("after_pulse", {30'd0, master_ready, master_error}, 32'd0);
    chk("after_rdata_hold", master_rdata, v.exp_rdata);
  endtask

  initial begin
    vecs[0] = '{32'h2000_0010, 32'h0, 4'h0, 3, K_READY, 32'hDEAD_BEEF, 4'b0100, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'hF000_0000, 32'h0, 4'h0, 0, K_NONE,  32'h0,         4'b0000, 1'b1, 32'h0};
    vecs[2] = '{32'h1000_1000, 32'h0, 4'h0, 8, K_NONE,  32'h7777_7777, 4'b0010, 1'b1, 32'h0};
    vecs[3] = '{32'h0000_0004, 32'h0, 4'h0, 2, K_BOTH,  32'h1111_2222, 4'b0001, 1'b1, 32'h0};
    vecs[4] = '{32'h1000_2000, 32'h0, 4'h0, 8, K_READY, 32'h1234_5678, 4'b0010, 1'b0, 32'h1234_5678};
    vecs[5] = '{32'h1000_0010, 32'h0, 4'h0, 0, K_NONE,  32'h0,         4'b0000, 1'b1, 32'h0};
    vecs[6] = '{32'h0000_0100, 32'hCAFE_F00D, 4'hF, 1, K_READY, 32'hAAAA_5555, 4'b0001, 1'b0, 32'hAAAA_5555};
    vecs[7] = '{32'h2000_0020, 32'h0, 4'h0, 1, K_ERROR, 32'h9999_9999, 4'b0100, 1'b1, 32'h0};
    vecs[8] = '{32'h1000_FFFC, 32'h0, 4'h0, 2, K_READY, 32'h0BAD_F00D, 4'b0010, 1'b0, 32'h0BAD_F00D};

    rst            = 1'b1;
    master_address = 32'd0;
    master_wdata   = 32'd0;
    master_wsel    = 4'd0;
    master_valid   = 1'b0;
    clear_slaves();
    tick();
    tick();
    chk("reset_sv", {28'd0, slave_valid}, 32'd0);
    chk("reset_pulses", {30'd0, master_ready, master_error}, 32'd0);
    chk("reset_rdata", master_rdata, 32'd0);
    chk("reset_addr", slave_address, 32'd0);
    chk("reset_wdata", slave_wdata, 32'd0);
    chk("reset_wsel", {28'd0, slave_wsel}, 32'd0);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 9; n++) begin
      do_txn(vecs[n]);
    end

    // A slave_ready arriving after a timeout must not produce a response
    do_txn(vecs[2]);
    slave_ready = 4'hF;
    slave_rdata = {4{32'h4444_4444}};
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("late_ready_pulses", {30'd0, master_ready, master_error}, 32'd0);
      chk("late_ready_sv", {28'd0, slave_valid}, 32'd0);
      chk("late_ready_rdata", master_rdata, 32'd0);
    end
    clear_slaves();

    // Back-to-back: write slave 0, then read slave 1 presented during the response cycle
    master_address = 32'h0000_0200;
    master_wdata   = 32'h0123_4567;
    master_wsel    = 4'hF;
    master_valid   = 1'b1;
    tick();
    chk("b2b_w_sv", {28'd0, slave_valid}, 32'h1);
    chk("b2b_w_wdata", slave_wdata, 32'h0123_4567);
    drive_slaves(4'b0001, 1'b1, 1'b0, 32'h0000_00AA);
    tick();
    chk("b2b_w_rdy", {31'd0, master_ready}, 32'd1);
    clear_slaves();
    master_address = 32'h1000_3000;
    master_wdata   = 32'd0;
    master_wsel    = 4'h0;
    tick();
    chk("b2b_idle_sv", {28'd0, slave_valid}, 32'd0);
    chk("b2b_idle_rdy", {31'd0, master_ready}, 32'd0);
    tick();
    chk("b2b_r_sv", {28'd0, slave_valid}, 32'h2);
    chk("b2b_r_addr", slave_address, 32'h1000_3000);
    chk("b2b_r_wsel", {28'd0, slave_wsel}, 32'd0);
    drive_slaves(4'b0010, 1'b1, 1'b0, 32'h600D_CAFE);
    tick();
    chk("b2b_r_rdy", {31'd0, master_ready}, 32'd1);
    chk("b2b_r_rdata", master_rdata, 32'h600D_CAFE);
    master_valid = 1'b0;
    clear_slaves();
    tick();

    // Reset in the middle of an access aborts it without a master response
    master_address = 32'h2000_0040;
    master_valid   = 1'b1;
    tick();
    chk("abort_sv_before", {28'd0, slave_valid}, 32'h4);
    tick();
    rst          = 1'b1;
    master_valid = 1'b0;
    tick();
    chk("abort_sv", {28'd0, slave_valid}, 32'd0);
    chk("abort_pulses", {30'd0, master_ready, master_error}, 32'd0);
    chk("abort_rdata", master_rdata, 32'd0);
    chk("abort_addr", slave_address, 32'd0);
    rst         = 1'b0;
    slave_ready = 4'hF;
    tick();
    chk("abort_no_resp", {30'd0, master_ready, master_error}, 32'd0);
    clear_slaves();
    tick();
    do_txn(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
